// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_fifo
//  Description : UART transmitter with a small input FIFO. Serialises
//                DATA_BITS-wide words LSB first with optional odd/even parity
//                and one or two stop bits. Queued words leave back-to-back.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 87,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                            i_Clock,
    input  logic                            i_Reset,
    input  logic                            i_Tx_DV,
    input  logic [DATA_BITS-1:0]            i_Tx_Data,
    output logic                            o_Tx_Ready,
    output logic [$clog2(FIFO_DEPTH):0]     o_Fifo_Count,
    output logic                            o_Tx_Active,
    output logic                            o_Tx_Serial,
    output logic                            o_Tx_Done
);

    localparam int c_CNT_W  = $clog2(CLKS_PER_BIT);
    localparam int c_IDX_W  = $clog2(DATA_BITS);
    localparam int c_AW     = $clog2(FIFO_DEPTH);
    localparam int c_CW     = c_AW + 1;

    localparam logic [c_CNT_W-1:0] c_CLK_LAST  = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST  = c_IDX_W'(DATA_BITS - 1);
    localparam logic               c_STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic [c_CW-1:0]    c_FULL      = c_CW'(FIFO_DEPTH);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_START  = 3'd1;
    localparam logic [2:0] c_DATA   = 3'd2;
    localparam logic [2:0] c_PARITY = 3'd3;
    localparam logic [2:0] c_STOP   = 3'd4;

    // FIFO storage and bookkeeping
    logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
    logic [c_AW-1:0]      r_wr_ptr;
    logic [c_AW-1:0]      r_rd_ptr;
    logic [c_CW-1:0]      r_count;

    // Transmit engine
    logic [2:0]           r_state;
    logic [c_CNT_W-1:0]   r_clk_cnt;
    logic [c_IDX_W-1:0]   r_bit_idx;
    logic                 r_stop_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par;
    logic                 r_serial;
    logic                 r_active;
    logic                 r_done;

    logic                 w_full;
    logic                 w_push;
    logic                 w_last_stop;
    logic                 w_pop;
    logic [DATA_BITS-1:0] w_head;
    logic                 w_par;

    // Full is judged on the registered count only, so a same-cycle pop
    // never re-opens the FIFO until the following cycle.
    assign w_full      = (r_count == c_FULL);
    assign w_push      = i_Tx_DV && !w_full;
    assign w_last_stop = (r_state == c_STOP) && (r_clk_cnt == c_CLK_LAST) &&
                         (r_stop_cnt == c_STOP_LAST);
    assign w_pop       = ((r_state == c_IDLE) || w_last_stop) && (r_count != '0);
    assign w_head      = r_mem[r_rd_ptr];
    // Odd parity is the complement of the XOR reduction, even is the reduction itself.
    assign w_par       = (PARITY == 1) ? ~(^w_head) : (^w_head);

    // FIFO payload write (storage needs no reset; pointers qualify contents)
    always_ff @(posedge i_Clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_Tx_Data;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Frame sequencer with registered line, active and done outputs
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_state    <= c_IDLE;
            r_clk_cnt  <= '0;
            r_bit_idx  <= '0;
            r_stop_cnt <= 1'b0;
            r_shift    <= '0;
            r_par      <= 1'b0;
            r_serial   <= 1'b1;
            r_active   <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    r_serial  <= 1'b1;
                    r_clk_cnt <= '0;
                    if (w_pop) begin
                        r_state  <= c_START;
                        r_serial <= 1'b0;
                        r_active <= 1'b1;
                        r_shift  <= w_head;
                        r_par    <= w_par;
                    end
                end
                c_START: begin
                    if (r_clk_cnt == c_CLK_LAST) begin
                        r_clk_cnt <= '0;
                        r_bit_idx <= '0;
                        r_serial  <= r_shift[0];
                        r_state   <= c_DATA;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                c_DATA: begin
                    if (r_clk_cnt == c_CLK_LAST) begin
                        r_clk_cnt <= '0;
                        if (r_bit_idx == c_IDX_LAST) begin
                            r_bit_idx <= '0;
                            if (PARITY != 0) begin
                                r_serial <= r_par;
                                r_state  <= c_PARITY;
                            end else begin
                                r_serial   <= 1'b1;
                                r_stop_cnt <= 1'b0;
                                r_state    <= c_STOP;
                            end
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                            r_shift   <= r_shift >> 1;
                            r_serial  <= r_shift[1];
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                c_PARITY: begin
                    if (r_clk_cnt == c_CLK_LAST) begin
                        r_clk_cnt  <= '0;
                        r_serial   <= 1'b1;
                        r_stop_cnt <= 1'b0;
                        r_state    <= c_STOP;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                c_STOP: begin
                    if (r_clk_cnt == c_CLK_LAST) begin
                        r_clk_cnt <= '0;
                        if (r_stop_cnt == c_STOP_LAST) begin
                            r_stop_cnt <= 1'b0;
                            r_done     <= 1'b1;
                            // Chain straight into the next start bit when words are queued.
                            if (w_pop) begin
                                r_state  <= c_START;
                                r_serial <= 1'b0;
                                r_shift  <= w_head;
                                r_par    <= w_par;
                            end else begin
                                r_state  <= c_IDLE;
                                r_serial <= 1'b1;
                                r_active <= 1'b0;
                            end
                        end else begin
                            r_stop_cnt <= r_stop_cnt + 1'b1;
                        end
                    end else begin
                        r_clk_cnt <= r_clk_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state   <= c_IDLE;
                    r_clk_cnt <= '0;
                    r_serial  <= 1'b1;
                    r_active  <= 1'b0;
                end
            endcase
        end
    end

    assign o_Tx_Ready   = !w_full;
    assign o_Fifo_Count = r_count;
    assign o_Tx_Active  = r_active;
    assign o_Tx_Serial  = r_serial;
    assign o_Tx_Done    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_fifo
//  Description : Directed self-checking bench for uart_tx_fifo. Four
//                instances cover 8E1, 8O1, 5N2 and 8N1 at CLKS_PER_BIT=4.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_fifo;

    logic       clk;
    logic       rst;
    logic [3:0] r_dv;
    logic [8:0] r_wdata;
    logic [3:0] w_ser, w_act, w_dn, w_rdy;
    logic [2:0] w_cnt [4];

    int n_checks;
    int n_fail;
    int sel;

    logic [7:0] wq [8];
    logic       cap_ser [256];
    logic       cap_act [256];
    logic       cap_dn  [256];
    logic       cap_rdy [256];
    logic [2:0] cap_cnt [256];

    // 0: 8E1, 1: 8O1, 2: 5N2, 3: 8N1
    uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u_even (
        .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(r_dv[0]), .i_Tx_Data(r_wdata[7:0]),
        .o_Tx_Ready(w_rdy[0]), .o_Fifo_Count(w_cnt[0]), .o_Tx_Active(w_act[0]),
        .o_Tx_Serial(w_ser[0]), .o_Tx_Done(w_dn[0]));
    uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(4)) u_odd (
        .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(r_dv[1]), .i_Tx_Data(r_wdata[7:0]),
        .o_Tx_Ready(w_rdy[1]), .o_Fifo_Count(w_cnt[1]), .o_Tx_Active(w_act[1]),
        .o_Tx_Serial(w_ser[1]), .o_Tx_Done(w_dn[1]));
    uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(5), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(4)) u_short (
        .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(r_dv[2]), .i_Tx_Data(r_wdata[4:0]),
        .o_Tx_Ready(w_rdy[2]), .o_Fifo_Count(w_cnt[2]), .o_Tx_Active(w_act[2]),
        .o_Tx_Serial(w_ser[2]), .o_Tx_Done(w_dn[2]));
    uart_tx_fifo #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u_8n1 (
        .i_Clock(clk), .i_Reset(rst), .i_Tx_DV(r_dv[3]), .i_Tx_Data(r_wdata[7:0]),
        .o_Tx_Ready(w_rdy[3]), .o_Fifo_Count(w_cnt[3]), .o_Tx_Active(w_act[3]),
        .o_Tx_Serial(w_ser[3]), .o_Tx_Done(w_dn[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Writes wq[0..n-1] to the selected instance on consecutive edges
    task automatic drive_words(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            r_dv[sel] = 1'b1;
            r_wdata   = {1'b0, wq[k]};
        end
        @(negedge clk);
        r_dv[sel] = 1'b0;
    endtask

    // Records outputs of the selected instance on n consecutive falling edges
    task automatic capture(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cap_ser[i] = w_ser[sel];
            cap_act[i] = w_act[sel];
            cap_dn[i]  = w_dn[sel];
            cap_rdy[i] = w_rdy[sel];
            cap_cnt[i] = w_cnt[sel];
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (w_ser[i] !== 1'b1) begin n_fail++; $display("FAIL reset_serial[%0d]: got %b want 1", i, w_ser[i]); end
            n_checks++; if (w_act[i] !== 1'b0) begin n_fail++; $display("FAIL reset_active[%0d]: got %b want 0", i, w_act[i]); end
            n_checks++; if (w_dn[i]  !== 1'b0) begin n_fail++; $display("FAIL reset_done[%0d]: got %b want 0", i, w_dn[i]); end
            n_checks++; if (w_rdy[i] !== 1'b1) begin n_fail++; $display("FAIL reset_ready[%0d]: got %b want 1", i, w_rdy[i]); end
            n_checks++; if (w_cnt[i] !== 3'd0) begin n_fail++; $display("FAIL reset_count[%0d]: got %0d want 0", i, w_cnt[i]); end
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    // 0xA5 8E1: start, 1,0,1,0,0,1,0,1, parity 0, stop
    task automatic test_even_parity();
        logic [10:0] exp_f;
        int n_act, n_dn;
        exp_f = 11'b1_0_10100101_0;
        sel = 0; wq[0] = 8'hA5;
        fork
            drive_words(1);
            begin @(negedge clk); capture(47); end
        join
        n_checks++; if (cap_ser[0] !== 1'b1) begin n_fail++; $display("FAIL even_pre_idle: got %b want 1", cap_ser[0]); end
        for (int c = 1; c <= 44; c++) begin
            n_checks++;
            if (cap_ser[c] !== exp_f[(c-1)/4]) begin n_fail++; $display("FAIL even_line cycle %0d: got %b want %b", c, cap_ser[c], exp_f[(c-1)/4]); end
        end
        n_act = 0; n_dn = 0;
        for (int c = 0; c < 47; c++) begin
            if (cap_act[c] === 1'b1) n_act++;
            if (cap_dn[c]  === 1'b1) n_dn++;
        end
        n_checks++; if (n_act != 44) begin n_fail++; $display("FAIL even_active_len: got %0d want 44", n_act); end
        n_checks++; if (n_dn != 1) begin n_fail++; $display("FAIL even_done_count: got %0d want 1", n_dn); end
        n_checks++; if (cap_dn[45] !== 1'b1) begin n_fail++; $display("FAIL even_done_pos: got %b want 1", cap_dn[45]); end
        n_checks++; if (cap_ser[46] !== 1'b1) begin n_fail++; $display("FAIL even_post_idle: got %b want 1", cap_ser[46]); end
    endtask

    // 0x01 -> parity 0, 0x03 -> parity 1 with odd parity
    task automatic test_odd_parity();
        logic [10:0] exp_f [2];
        exp_f[0] = 11'b1_0_00000001_0;
        exp_f[1] = 11'b1_1_00000011_0;
        sel = 1;
        for (int w = 0; w < 2; w++) begin
            wq[0] = (w == 0) ? 8'h01 : 8'h03;
            fork
                drive_words(1);
                begin @(negedge clk); capture(46); end
            join
            for (int c = 1; c <= 44; c++) begin
                n_checks++;
                if (cap_ser[c] !== exp_f[w][(c-1)/4]) begin n_fail++; $display("FAIL odd_line w%0d cycle %0d: got %b want %b", w, c, cap_ser[c], exp_f[w][(c-1)/4]); end
            end
            n_checks++; if (cap_dn[45] !== 1'b1) begin n_fail++; $display("FAIL odd_done w%0d: got %b want 1", w, cap_dn[45]); end
        end
    endtask

    // 0x1F 5N2: start, five ones, two stop bits -> 32 cycles
    task automatic test_two_stop();
        logic [7:0] exp_f;
        exp_f = 8'b1111_1110;
        sel = 2; wq[0] = 8'h1F;
        fork
            drive_words(1);
            begin @(negedge clk); capture(35); end
        join
        for (int c = 1; c <= 32; c++) begin
            n_checks++;
            if (cap_ser[c] !== exp_f[(c-1)/4]) begin n_fail++; $display("FAIL short_line cycle %0d: got %b want %b", c, cap_ser[c], exp_f[(c-1)/4]); end
            n_checks++;
            if (cap_act[c] !== 1'b1) begin n_fail++; $display("FAIL short_active cycle %0d: got %b want 1", c, cap_act[c]); end
        end
        n_checks++; if (cap_dn[32] !== 1'b0) begin n_fail++; $display("FAIL short_done_early: got %b want 0", cap_dn[32]); end
        n_checks++; if (cap_dn[33] !== 1'b1) begin n_fail++; $display("FAIL short_done: got %b want 1", cap_dn[33]); end
        n_checks++; if (cap_act[33] !== 1'b0) begin n_fail++; $display("FAIL short_active_fall: got %b want 0", cap_act[33]); end
    endtask

    // Three words on consecutive cycles leave as three gap-free frames
    task automatic test_back_to_back();
        logic [9:0] fr [3];
        logic       exp_dn;
        sel = 3; wq[0] = 8'h00; wq[1] = 8'hFF; wq[2] = 8'h55;
        for (int f = 0; f < 3; f++) fr[f] = {1'b1, wq[f], 1'b0};
        fork
            drive_words(3);
            begin @(negedge clk); capture(123); end
        join
        n_checks++; if (cap_cnt[2] !== 3'd2) begin n_fail++; $display("FAIL b2b_count: got %0d want 2", cap_cnt[2]); end
        for (int c = 1; c <= 120; c++) begin
            n_checks++;
            if (cap_ser[c] !== fr[(c-1)/40][((c-1)%40)/4]) begin n_fail++; $display("FAIL b2b_line cycle %0d: got %b want %b", c, cap_ser[c], fr[(c-1)/40][((c-1)%40)/4]); end
            n_checks++;
            if (cap_act[c] !== 1'b1) begin n_fail++; $display("FAIL b2b_active cycle %0d: got %b want 1", c, cap_act[c]); end
        end
        for (int c = 0; c < 123; c++) begin
            exp_dn = (c == 41) || (c == 81) || (c == 121);
            n_checks++;
            if (cap_dn[c] !== exp_dn) begin n_fail++; $display("FAIL b2b_done cycle %0d: got %b want %b", c, cap_dn[c], exp_dn); end
        end
        n_checks++; if (cap_act[121] !== 1'b0) begin n_fail++; $display("FAIL b2b_active_fall: got %b want 0", cap_act[121]); end
    endtask

    // Six words into a depth-4 FIFO: one in flight, four queued, one dropped
    task automatic test_overflow();
        logic [9:0] fr [5];
        logic       exp_dn;
        sel = 3;
        wq[0] = 8'h11; wq[1] = 8'h22; wq[2] = 8'h33;
        wq[3] = 8'h44; wq[4] = 8'h55; wq[5] = 8'h66;
        for (int f = 0; f < 5; f++) fr[f] = {1'b1, wq[f], 1'b0};
        fork
            drive_words(6);
            begin @(negedge clk); capture(203); end
        join
        n_checks++; if (cap_cnt[3] !== 3'd3) begin n_fail++; $display("FAIL ovf_count3: got %0d want 3", cap_cnt[3]); end
        n_checks++; if (cap_rdy[3] !== 1'b1) begin n_fail++; $display("FAIL ovf_ready3: got %b want 1", cap_rdy[3]); end
        n_checks++; if (cap_cnt[4] !== 3'd4) begin n_fail++; $display("FAIL ovf_count_full: got %0d want 4", cap_cnt[4]); end
        n_checks++; if (cap_rdy[4] !== 1'b0) begin n_fail++; $display("FAIL ovf_ready_full: got %b want 0", cap_rdy[4]); end
        n_checks++; if (cap_cnt[5] !== 3'd4) begin n_fail++; $display("FAIL ovf_drop_count: got %0d want 4", cap_cnt[5]); end
        for (int c = 1; c <= 200; c++) begin
            n_checks++;
            if (cap_ser[c] !== fr[(c-1)/40][((c-1)%40)/4]) begin n_fail++; $display("FAIL ovf_line cycle %0d: got %b want %b", c, cap_ser[c], fr[(c-1)/40][((c-1)%40)/4]); end
        end
        for (int c = 0; c < 203; c++) begin
            exp_dn = (c == 41) || (c == 81) || (c == 121) || (c == 161) || (c == 201);
            n_checks++;
            if (cap_dn[c] !== exp_dn) begin n_fail++; $display("FAIL ovf_done cycle %0d: got %b want %b", c, cap_dn[c], exp_dn); end
        end
        n_checks++; if (cap_act[201] !== 1'b0) begin n_fail++; $display("FAIL ovf_active_fall: got %b want 0", cap_act[201]); end
        n_checks++; if (cap_cnt[202] !== 3'd0) begin n_fail++; $display("FAIL ovf_final_count: got %0d want 0", cap_cnt[202]); end
    endtask

    // Reset during the data bits with two words queued aborts everything
    task automatic test_reset_mid_frame();
        int n_dn, n_low, n_act;
        sel = 3;
        wq[0] = 8'h0F; wq[1] = 8'h33; wq[2] = 8'hC3;
        fork
            drive_words(3);
            begin @(negedge clk); capture(12); end
        join
        n_checks++; if (cap_cnt[11] !== 3'd2) begin n_fail++; $display("FAIL midrst_queued: got %0d want 2", cap_cnt[11]); end
        n_checks++; if (cap_act[11] !== 1'b1) begin n_fail++; $display("FAIL midrst_in_frame: got %b want 1", cap_act[11]); end
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (w_ser[3] !== 1'b1) begin n_fail++; $display("FAIL midrst_serial: got %b want 1", w_ser[3]); end
        n_checks++; if (w_act[3] !== 1'b0) begin n_fail++; $display("FAIL midrst_active: got %b want 0", w_act[3]); end
        n_checks++; if (w_cnt[3] !== 3'd0) begin n_fail++; $display("FAIL midrst_count: got %0d want 0", w_cnt[3]); end
        n_checks++; if (w_rdy[3] !== 1'b1) begin n_fail++; $display("FAIL midrst_ready: got %b want 1", w_rdy[3]); end
        n_checks++; if (w_dn[3]  !== 1'b0) begin n_fail++; $display("FAIL midrst_done: got %b want 0", w_dn[3]); end
        rst = 1'b0;
        capture(90);
        n_dn = 0; n_low = 0; n_act = 0;
        for (int c = 0; c < 90; c++) begin
            if (cap_dn[c]  !== 1'b0) n_dn++;
            if (cap_ser[c] !== 1'b1) n_low++;
            if (cap_act[c] !== 1'b0) n_act++;
        end
        n_checks++; if (n_dn != 0) begin n_fail++; $display("FAIL midrst_no_done: got %0d pulses want 0", n_dn); end
        n_checks++; if (n_low != 0) begin n_fail++; $display("FAIL midrst_line_idle: got %0d non-idle cycles want 0", n_low); end
        n_checks++; if (n_act != 0) begin n_fail++; $display("FAIL midrst_no_frames: got %0d active cycles want 0", n_act); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        sel      = 0;
        rst      = 1'b1;
        r_dv     = 4'b0000;
        r_wdata  = 9'd0;
        test_reset();
        test_even_parity();
        test_odd_parity();
        test_two_stop();
        test_back_to_back();
        test_overflow();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter that serialises words of configurable width, with optional parity and one or two stop bits. A small input FIFO lets queued words go out back-to-back with no idle gap between frames. It sits between the on-chip test logic (for example, ISERDES capture dumpers) and the board UART pin. It is a drop-in successor to the single-byte transmitter: one clock, registered serial output, and a one-cycle done pulse per frame.

## Interface
- CLKS_PER_BIT, 87: clock cycles per bit, i_Clock frequency / baud. Must be ≥ 2.
- DATA_BITS, 8: data bits per frame, legal range 5..9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.
- FIFO_DEPTH, 4: input FIFO entries. Power of two, ≥ 2.
- i_Clock  in  1  sole clock; all logic on rising edge.
- i_Reset  in  1  synchronous, active-high reset.
- i_Tx_DV  in  1  write strobe; accepted only when o_Tx_Ready = 1.
- i_Tx_Data  in  DATA_BITS  word to transmit, sampled with i_Tx_DV.
- o_Tx_Ready  out  1  FIFO not full (combinational from count).
- o_Fifo_Count  out  $clog2(FIFO_DEPTH)+1  entries currently queued (excludes the word in flight).
- o_Tx_Active  out  1  a frame is on the line.
- o_Tx_Serial  out  1  registered serial line; idles high.
- o_Tx_Done  out  1  one-cycle pulse per completed frame.

## Operation
- Frame: start (0), DATA_BITS data bits LSB first, optional parity bit, STOP_BITS stop bits (1).
- Each bit is held exactly CLKS_PER_BIT cycles.
- Frame length is CLKS_PER_BIT × (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) cycles.
- Parity is computed over the word as popped.
  - Odd: the parity bit makes the total count of ones (data + parity) odd.
  - Even: the parity bit makes that total even.
- FIFO write: i_Tx_DV && o_Tx_Ready pushes i_Tx_Data. A write while full is dropped with no state change.
- FIFO pop: occurs in IDLE, or on the final cycle of the last stop bit, whenever the FIFO is non-empty.
- Push and pop in the same cycle: count unchanged, data order preserved.
- Ready rule: a full FIFO deasserts o_Tx_Ready even if a pop happens in the same cycle. The freed slot shows the cycle after.
- State machine:
  - IDLE → START on pop.
  - START → DATA after CLKS_PER_BIT cycles.
  - DATA → PARITY, or → STOP when PARITY = 0, after DATA_BITS bit periods.
  - PARITY → STOP after one bit period.
  - STOP → START if the FIFO is non-empty at the end of the last stop bit, else → IDLE.
  - Undefined encodings → IDLE.
- Internal counters:
  - Bit-period counter: $clog2(CLKS_PER_BIT) bits, counting 0..CLKS_PER_BIT-1, cleared on every bit boundary.
  - Bit-index counter: counts 0..DATA_BITS-1.
  - Stop counter: counts 0..STOP_BITS-1.
- Reset values: o_Tx_Serial = 1, o_Tx_Active = 0, o_Tx_Done = 0, o_Fifo_Count = 0, o_Tx_Ready = 1, state IDLE, all counters 0.
- Reset mid-frame: the frame is aborted and queued words are discarded. On the next edge the line is 1 and no Done pulse is produced.

## Timing
- Let a write be sampled at edge N into an empty FIFO with the engine in IDLE.
  - Edge N+1: pop occurs, o_Tx_Serial = 0, o_Tx_Active = 1.
  - First data bit appears at edge N+1+CLKS_PER_BIT.
- o_Tx_Active is high from the first start-bit cycle through the last stop-bit cycle.
  - It stays high continuously across back-to-back frames.
  - It falls on the edge where the engine returns to IDLE.
- o_Tx_Done is high for exactly one cycle, the first cycle after the last stop-bit cycle.
  - In back-to-back operation this is the first start-bit cycle of the next frame.
- No idle gap between queued frames: the stop bit is followed directly by the next start bit.
- o_Fifo_Count and o_Tx_Ready reflect pushes and pops the cycle after the edge on which they occur.

## Test plan
- Even parity: CLKS_PER_BIT=4, DATA_BITS=8, PARITY=2, STOP_BITS=1; write 0xA5 → line 0,1,0,1,0,0,1,0,1,0(parity),1, each held 4 cycles (44 cycles). One Done pulse; Active high for exactly 44 cycles.
- Odd parity: PARITY=1; 0x01 → parity bit 0; 0x03 → parity bit 1.
- Short frame with two stop bits: DATA_BITS=5, PARITY=0, STOP_BITS=2; write 0x1F → 0,1,1,1,1,1,1,1 = 32 cycles at CLKS_PER_BIT=4.
- Back-to-back: 8N1 config, write 0x00, 0xFF, 0x55 on three consecutive cycles → 3 frames in 120 cycles. Active continuously high; Done pulses at cycles 41, 81, 121 after the first write; no high gap between frames.
- Overflow: FIFO_DEPTH=4; write 6 words on 6 consecutive cycles. First pops to the engine; next 4 fill the FIFO (Ready = 0, count = 4); the 6th is dropped. Exactly 5 frames are emitted, in write order.
- Reset mid-frame: assert i_Reset during the DATA state with 2 words queued → next edge line = 1, Active = 0, count = 0, Ready = 1. No Done pulse and no further frames.
